// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, PC constants and fetch-entry type for the MIPS32 core
package mips_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  // Branch/jump targets are always word aligned; the low byte-offset bits are dropped.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// rtl/ifetch_ctrl_if.sv - instruction ROM port and decode handshake of the fetch stage
interface ifetch_ctrl_if;
  import mips_pkg::*;

  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_inst;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_inst,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );

endinterface

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - DEPTH-entry synchronous prefetch queue with flush
module ifetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign pop_ok   = pop & ~empty;
  // A full queue may accept a push when the head leaves in the same cycle.
  assign push_ok  = push & (~full | pop_ok) & ~flush;
  assign pop_data = mem[head];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + 1'b1;
      end
      if (pop_ok) begin
        head <= head + 1'b1;
      end
      count <= count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
    end
  end

  // Entry storage is data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= DEPTH_C)
        else $error("ifetch_fifo count above depth");
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - PC sequencer feeding the ROM, prefetch queue and redirect handling
module ifetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       fetch_cnt,
  ifetch_ctrl_if.master     bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic              deq;
  logic              enq;
  logic              space;
  logic              q_full;
  logic              q_empty;
  logic [PTR_W:0]    q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_push;

  assign bus.imem_addr = pc;

  assign deq   = bus.out_valid & bus.out_ready;
  assign space = ~q_full | deq;
  // Control depends only on handshake state, never on the fetched word itself.
  assign enq   = fetch_en & space & ~redirect;

  assign q_push.inst = bus.imem_inst;
  assign q_push.pc   = pc;

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enq),
    .push_data (q_push),
    .pop       (deq),
    .flush     (redirect),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign bus.out_valid = ~q_empty;
  assign bus.out_inst  = q_empty ? '0 : q_head.inst;
  assign bus.out_pc    = q_empty ? '0 : q_head.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      fetch_cnt <= '0;
    end else if (redirect) begin
      pc <= align_word(redirect_pc);
    end else if (enq) begin
      pc        <= pc + PC_STEP;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  logic unused_count;
  assign unused_count = ^q_count;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - scoreboard bench for ifetch_ctrl against a queue-based reference model
module tb_ifetch_ctrl;
  import mips_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] rom [32];

  ifetch_ctrl_if bus ();

  ifetch_ctrl #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_cnt   (fetch_cnt),
    .bus         (bus.master)
  );

  assign bus.imem_inst = rom[bus.imem_addr[6:2]];

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: a plain list of fetched {inst, pc} pairs still owed to decode.
  fetch_entry_t mq[$];
  logic [31:0]  mpc;
  logic [31:0]  mcnt;
  bit           m_deq, m_space, m_enq;
  fetch_entry_t m_cur;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mpc  = RST_PC;
      mcnt = 0;
    end else begin
      m_deq   = (mq.size() > 0) && bus.out_ready;
      m_space = (mq.size() < DEPTH) || m_deq;
      m_enq   = fetch_en && m_space && !redirect;
      m_cur.inst = rom[mpc[6:2]];
      m_cur.pc   = mpc;
      if (m_deq) void'(mq.pop_front());
      if (redirect) begin
        mq.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else if (m_enq) begin
        mq.push_back(m_cur);
        mpc  = mpc + 32'd4;
        mcnt = mcnt + 32'd1;
      end
    end
  end

  // Monitor: compare what the DUT presents against the head of the model queue.
  always @(posedge clk) begin
    #1;
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, mq.size() > 0});
    if (mq.size() > 0) begin
      check("out_inst", bus.out_inst, mq[0].inst);
      check("out_pc", bus.out_pc, mq[0].pc);
    end else begin
      check("out_inst_empty", bus.out_inst, 32'h0);
      check("out_pc_empty", bus.out_pc, 32'h0);
    end
    check("imem_addr", bus.imem_addr, mpc);
    check("fetch_cnt", fetch_cnt, mcnt);
  end

  task automatic drive(input logic r, input logic fe, input logic rdy,
                       input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; fetch_en = fe; bus.out_ready = rdy; redirect = rd; redirect_pc = rpc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rom[0] = 32'h2001_0008;
    rom[1] = 32'h3402_000C;
    for (int i = 2; i < 32; i++) rom[i] = $urandom;
    rst = 1'b1; fetch_en = 1'b1; bus.out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;

    // Bring-up: first word one cycle after reset release.
    drive(1, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    @(posedge clk); #2;
    check("bringup_inst0", bus.out_inst, 32'h2001_0008);
    check("bringup_pc0", bus.out_pc, 32'h0);
    @(posedge clk); #2;
    check("bringup_inst1", bus.out_inst, 32'h3402_000C);
    check("bringup_pc1", bus.out_pc, 32'h4);
    repeat (3) drive(0, 1, 1, 0, 0);

    // Back-pressure from reset: queue fills, pc holds at 8.
    drive(1, 1, 0, 0, 0);
    repeat (5) drive(0, 1, 0, 0, 0);
    check("stall_addr", bus.imem_addr, 32'h8);
    check("stall_cnt", fetch_cnt, 32'd2);
    check("stall_head", bus.out_inst, 32'h2001_0008);
    repeat (6) drive(0, 1, 1, 0, 0);

    // Redirect with a full queue.
    repeat (2) drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 32'h0000_0031);
    drive(0, 1, 1, 0, 0);
    check("redir_valid", {31'b0, bus.out_valid}, 32'h0);
    check("redir_addr", bus.imem_addr, 32'h30);
    drive(0, 1, 1, 0, 0);
    check("redir_pc", bus.out_pc, 32'h30);
    check("redir_inst", bus.out_inst, rom[12]);
    repeat (3) drive(0, 1, 1, 0, 0);

    // Fetch pause with a redirect inside it.
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 32'h0000_0024);
    drive(0, 0, 1, 0, 0);
    check("pause_valid", {31'b0, bus.out_valid}, 32'h0);
    check("pause_addr", bus.imem_addr, 32'h24);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    check("resume_pc", bus.out_pc, 32'h24);

    // PC wrap across 2^32.
    drive(0, 1, 1, 1, 32'hFFFF_FFFF);
    repeat (4) drive(0, 1, 1, 0, 0);

    // Reset beats a simultaneous redirect with a full queue.
    repeat (3) drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 32'h0000_0040);
    drive(0, 1, 1, 0, 0);
    check("rst_addr", bus.imem_addr, RST_PC);
    check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_cnt", fetch_cnt, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 99) < 1),
            ($urandom_range(0, 99) < 80),
            ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 5),
            $urandom_range(0, 127));
    end
    drive(0, 1, 1, 0, 0);
    @(posedge clk); #3;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
